// File: rtl/vga_sync_if.sv
// vga_sync_if: raster timing bundle from the sync generator to the colour stage
//   horizontal/vertical : current pixel column / line
//   hsync/vsync         : sync pulses, active level set by the generator
//   video_on            : inside the visible area
//   pixel_tick          : counters advance on this cycle's edge
//   frame_start         : first cycle of a new frame at (0,0)
interface vga_sync_if;
    logic [9:0] horizontal;
    logic [9:0] vertical;
    logic       hsync;
    logic       vsync;
    logic       video_on;
    logic       pixel_tick;
    logic       frame_start;
    modport master(output horizontal, vertical, hsync, vsync, video_on, pixel_tick, frame_start);
    modport slave(input horizontal, vertical, hsync, vsync, video_on, pixel_tick, frame_start);
endinterface

// File: rtl/vga_sync_generator.sv
// vga_sync_generator: pixel-rate divider plus h/v raster counters with registered sync decode
//   clk_in   : system clock, all logic on posedge
//   reset_in : synchronous reset, active-high
//   vga      : vga_sync_if master (counters, syncs, video_on, pixel_tick, frame_start)
module vga_sync_generator #(
    parameter int H_VISIBLE = 640,
    parameter int H_FRONT   = 16,
    parameter int H_SYNC    = 96,
    parameter int H_BACK    = 48,
    parameter int V_VISIBLE = 480,
    parameter int V_FRONT   = 10,
    parameter int V_SYNC    = 2,
    parameter int V_BACK    = 33,
    parameter int CLK_DIV   = 2,
    parameter bit SYNC_POL  = 1'b0
) (
    input logic        clk_in,
    input logic        reset_in,
    vga_sync_if.master vga
);
    localparam int H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
    localparam int V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;
    localparam int DW = CLK_DIV > 1 ? $clog2(CLK_DIV) : 1;
    localparam logic [9:0] H_LAST = 10'(H_TOTAL - 1);
    localparam logic [9:0] V_LAST = 10'(V_TOTAL - 1);
    localparam logic [9:0] HS_FIRST = 10'(H_VISIBLE + H_FRONT);
    localparam logic [9:0] HS_LAST = 10'(H_VISIBLE + H_FRONT + H_SYNC - 1);
    localparam logic [9:0] VS_FIRST = 10'(V_VISIBLE + V_FRONT);
    localparam logic [9:0] VS_LAST = 10'(V_VISIBLE + V_FRONT + V_SYNC - 1);
    localparam logic [9:0] H_VIS = 10'(H_VISIBLE);
    localparam logic [9:0] V_VIS = 10'(V_VISIBLE);
    if (H_TOTAL > 1024 || V_TOTAL > 1024 || CLK_DIV < 1) begin : g_bad_params
        $error("vga_sync_generator: totals must be <= 1024 and CLK_DIV >= 1");
    end
    logic [DW-1:0] div;
    logic [9:0]    h, v, h_nxt, v_nxt;
    logic          tick, h_wrap, v_wrap;
    logic          hsync_q, vsync_q, video_on_q, frame_start_q;
    always_comb begin
        tick   = div == DW'(CLK_DIV - 1);
        h_wrap = h == H_LAST;
        v_wrap = v == V_LAST;
        h_nxt  = !tick ? h : h_wrap ? '0 : h + 10'd1;
        v_nxt  = !(tick && h_wrap) ? v : v_wrap ? '0 : v + 10'd1;
    end
    // Syncs and video_on decode the next-state counters so they line up with h/v.
    always_ff @(posedge clk_in) begin
        if (reset_in) begin
            div           <= '0;
            h             <= '0;
            v             <= '0;
            hsync_q       <= ~SYNC_POL;
            vsync_q       <= ~SYNC_POL;
            video_on_q    <= 1'b0;
            frame_start_q <= 1'b0;
        end else begin
            div           <= tick ? '0 : div + DW'(1);
            h             <= h_nxt;
            v             <= v_nxt;
            hsync_q       <= (h_nxt >= HS_FIRST && h_nxt <= HS_LAST) ? SYNC_POL : ~SYNC_POL;
            vsync_q       <= (v_nxt >= VS_FIRST && v_nxt <= VS_LAST) ? SYNC_POL : ~SYNC_POL;
            video_on_q    <= h_nxt < H_VIS && v_nxt < V_VIS;
            frame_start_q <= tick && h_wrap && v_wrap;
        end
    end
    assign vga.horizontal  = h;
    assign vga.vertical    = v;
    assign vga.hsync       = hsync_q;
    assign vga.vsync       = vsync_q;
    assign vga.video_on    = video_on_q;
    assign vga.pixel_tick  = tick;
    assign vga.frame_start = frame_start_q;
endmodule

// File: tb/tb_vga_sync_generator.sv
// tb_vga_sync_generator: scoreboard bench for two shrunken-raster generators
module tb_vga_sync_generator;
    localparam int HV = 8, HF = 2, HSW = 3, HB = 2;
    localparam int VV = 6, VF = 1, VSW = 2, VB = 2;
    localparam int HT = HV + HF + HSW + HB;
    localparam int VT = VV + VF + VSW + VB;

    typedef struct packed {
        logic [9:0] h;
        logic [9:0] v;
        logic [4:0] flags;
    } exp_t;

    logic clk = 1'b0;
    logic rst0 = 1'b1;
    logic rst1 = 1'b1;
    int   k0 = 0, k1 = 0;
    int   n_checks = 0, n_pass = 0;
    exp_t q0[$];
    exp_t q1[$];

    always #5 clk = ~clk;

    vga_sync_if vif0();
    vga_sync_if vif1();

    vga_sync_generator #(
        .H_VISIBLE(HV), .H_FRONT(HF), .H_SYNC(HSW), .H_BACK(HB),
        .V_VISIBLE(VV), .V_FRONT(VF), .V_SYNC(VSW), .V_BACK(VB),
        .CLK_DIV(2), .SYNC_POL(1'b0)
    ) dut0 (.clk_in(clk), .reset_in(rst0), .vga(vif0));

    vga_sync_generator #(
        .H_VISIBLE(HV), .H_FRONT(HF), .H_SYNC(HSW), .H_BACK(HB),
        .V_VISIBLE(VV), .V_FRONT(VF), .V_SYNC(VSW), .V_BACK(VB),
        .CLK_DIV(1), .SYNC_POL(1'b1)
    ) dut1 (.clk_in(clk), .reset_in(rst1), .vga(vif1));

    // k = edges since the last reset edge; n = pixel ticks consumed since then.
    function automatic exp_t model(input int k, input int d, input bit pol);
        exp_t e;
        int n, hh, vv;
        bit hs_on, vs_on;
        n     = k / d;
        hh    = n % HT;
        vv    = (n / HT) % VT;
        hs_on = k > 0 && hh >= HV + HF && hh < HV + HF + HSW;
        vs_on = k > 0 && vv >= VV + VF && vv < VV + VF + VSW;
        e.h   = 10'(hh);
        e.v   = 10'(vv);
        e.flags = {hs_on ? pol : ~pol,
                   vs_on ? pol : ~pol,
                   k > 0 && hh < HV && vv < VV,
                   (k % d) == d - 1,
                   k > 0 && (k % d) == 0 && (n % (HT * VT)) == 0};
        return e;
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s @%0t: got %0h expected %0h", tag, $time, got, exp);
    endtask

    task automatic cycle(input logic r0, input logic r1);
        exp_t e;
        rst0 = r0;
        rst1 = r1;
        @(posedge clk);
        k0 = r0 ? 0 : k0 + 1;
        k1 = r1 ? 0 : k1 + 1;
        q0.push_back(model(k0, 2, 1'b0));
        q1.push_back(model(k1, 1, 1'b1));
        @(negedge clk);
        e = q0.pop_front();
        check("d0.h", 32'(vif0.horizontal), 32'(e.h));
        check("d0.v", 32'(vif0.vertical), 32'(e.v));
        check("d0.hs_vs_von_tick_fs",
              32'({vif0.hsync, vif0.vsync, vif0.video_on, vif0.pixel_tick, vif0.frame_start}),
              32'(e.flags));
        e = q1.pop_front();
        check("d1.h", 32'(vif1.horizontal), 32'(e.h));
        check("d1.v", 32'(vif1.vertical), 32'(e.v));
        check("d1.hs_vs_von_tick_fs",
              32'({vif1.hsync, vif1.vsync, vif1.video_on, vif1.pixel_tick, vif1.frame_start}),
              32'(e.flags));
    endtask

    initial begin
        exp_t m;
        for (int i = 0; i < 3; i++) cycle(1'b1, 1'b1);
        for (int i = 0; i < 2 * HT * VT * 2 + 5; i++) cycle(1'b0, 1'b0);
        for (int i = 0; i < 2 * HT * VT * 2; i++) begin
            m = model(k0, 2, 1'b0);
            if (m.h == 10'(HV + HF + 1) && m.v == 10'(VV + VF)) break;
            cycle(1'b0, 1'b0);
        end
        cycle(1'b1, 1'b0);
        for (int i = 0; i < 40; i++) cycle(1'b0, 1'b0);
        for (int i = 0; i < 2 * HT * VT; i++) begin
            m = model(k1, 1, 1'b1);
            if (m.h == 10'(HV + HF + 1) && m.v == 10'(VV + VF)) break;
            cycle(1'b0, 1'b0);
        end
        cycle(1'b0, 1'b1);
        cycle(1'b0, 1'b1);
        for (int i = 0; i < 40; i++) cycle(1'b0, 1'b0);
        for (int i = 0; i < 800; i++)
            cycle(1'($urandom_range(0, 60) == 0), 1'($urandom_range(0, 60) == 0));
        for (int i = 0; i < HT * VT * 2 + 5; i++) cycle(1'b0, 1'b0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
